// File: rtl/instruction_fetch.sv
// instruction_fetch: front-end fetch stage. Holds the PC, reads one 32-bit word per clock
// from a local instruction memory and registers it on captured_data for decode.
//
// Ports:
//   clk            pipeline clock, rising-edge active
//   reset_n        asynchronous active-low reset
//   stall          hold pc, captured_data and valid this cycle
//   branch_taken   redirect pc to branch_target (wins over stall)
//   branch_target  redirect byte address, bits [1:0] ignored
//   prog_we        instruction memory write enable (works during reset)
//   prog_addr      word address for the program write
//   prog_data      word written to the instruction memory
//   captured_data  registered fetched instruction
//   pc             address of the next fetch
//   valid          captured_data holds a real fetched instruction
//   fault          sticky out-of-range fetch flag
//
// Optional feature macro: IF_BOUNDS_CHECK_EN
//   defined   - fetches with pc >= DEPTH*4 return NOP_INSTR and set the sticky fault flag
//   undefined - the fetch index wraps modulo DEPTH and fault is tied low
module instruction_fetch #(
    parameter int unsigned DEPTH     = 64,
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     stall,
    input  logic                     branch_taken,
    input  logic [31:0]              branch_target,
    input  logic                     prog_we,
    input  logic [$clog2(DEPTH)-1:0] prog_addr,
    input  logic [31:0]              prog_data,
    output logic [31:0]              captured_data,
    output logic [31:0]              pc,
    output logic                     valid,
    output logic                     fault
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [31:0]   mem_q [DEPTH];
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   captured_data_q, captured_data_d;
    logic          valid_q, valid_d;
    logic [AW-1:0] fetch_idx;
    logic [31:0]   fetch_word;

    // Target byte-offset bits are dropped by the redirect.
    logic unused_target_bits;
    assign unused_target_bits = ^branch_target[1:0];

    // Memory has no reset so it can be loaded while the pipeline is held in reset.
    always_ff @(posedge clk) begin
        if (prog_we) begin
            mem_q[prog_addr] <= prog_data;
        end
    end

    assign fetch_idx  = pc_q[AW+1:2];
    // Read of the current contents gives read-before-write on a same-word collision.
    assign fetch_word = mem_q[fetch_idx];

`ifdef IF_BOUNDS_CHECK_EN
    logic fault_q, fault_d;
    logic out_of_range;

    assign out_of_range = |pc_q[31:AW+2];
`endif

    always_comb begin
        pc_d            = pc_q;
        captured_data_d = captured_data_q;
        valid_d         = valid_q;
`ifdef IF_BOUNDS_CHECK_EN
        fault_d         = fault_q;
`endif
        if (branch_taken) begin
            pc_d            = {branch_target[31:2], 2'b00};
            captured_data_d = NOP_INSTR;
            valid_d         = 1'b0;
        end else if (!stall) begin
            pc_d            = pc_q + 32'd4;
            valid_d         = 1'b1;
`ifdef IF_BOUNDS_CHECK_EN
            if (out_of_range) begin
                captured_data_d = NOP_INSTR;
                fault_d         = 1'b1;
            end else begin
                captured_data_d = fetch_word;
            end
`else
            captured_data_d = fetch_word;
`endif
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pc_q            <= RESET_PC;
            captured_data_q <= 32'h0000_0000;
            valid_q         <= 1'b0;
        end else begin
            pc_q            <= pc_d;
            captured_data_q <= captured_data_d;
            valid_q         <= valid_d;
        end
    end

`ifdef IF_BOUNDS_CHECK_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            fault_q <= 1'b0;
        end else begin
            fault_q <= fault_d;
        end
    end

    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

    assign pc            = pc_q;
    assign captured_data = captured_data_q;
    assign valid         = valid_q;

endmodule

// File: tb/tb_instruction_fetch.sv
module tb_instruction_fetch;

    localparam int unsigned DEPTH = 64;
    localparam logic [31:0] NOP   = 32'h0000_0000;
`ifdef IF_BOUNDS_CHECK_EN
    localparam bit BC = 1'b1;
`else
    localparam bit BC = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        reset_n;
    logic        stall;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        prog_we;
    logic [5:0]  prog_addr;
    logic [31:0] prog_data;
    logic [31:0] captured_data;
    logic [31:0] pc;
    logic        valid;
    logic        fault;

    int checks   = 0;
    int failures = 0;

    logic [31:0] tb_mem [DEPTH];

    instruction_fetch #(
        .DEPTH    (DEPTH),
        .RESET_PC (32'h0000_0000),
        .NOP_INSTR(NOP)
    ) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .prog_we      (prog_we),
        .prog_addr    (prog_addr),
        .prog_data    (prog_data),
        .captured_data(captured_data),
        .pc           (pc),
        .valid        (valid),
        .fault        (fault)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        st;
        logic        br;
        logic [31:0] tgt;
        logic [31:0] cap;
        logic [31:0] pc;
        logic        valid;
        logic        fault;
    } vec_t;

    vec_t vecs[19];

    function automatic vec_t mk(input logic st, input logic br, input logic [31:0] tgt,
                                input logic [31:0] cap, input logic [31:0] p,
                                input logic v, input logic f);
        vec_t r;
        r.st = st; r.br = br; r.tgt = tgt; r.cap = cap; r.pc = p; r.valid = v; r.fault = f;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk_all(input string name, input logic [31:0] ecap, input logic [31:0] epc,
                           input logic ev, input logic ef);
        chk({name, ".captured_data"}, captured_data, ecap);
        chk({name, ".pc"}, pc, epc);
        chk({name, ".valid"}, {31'd0, valid}, {31'd0, ev});
        chk({name, ".fault"}, {31'd0, fault}, {31'd0, ef});
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic br, input logic [31:0] tgt);
        stall = st; branch_taken = br; branch_target = tgt;
    endtask

    // Reference model state (updated once per rising edge).
    logic [31:0] m_pc, m_cap;
    logic        m_valid, m_fault;

    task automatic model_edge(input logic st, input logic br, input logic [31:0] tgt,
                              input logic we, input logic [5:0] wa, input logic [31:0] wd);
        if (br) begin
            m_pc    = tgt & 32'hFFFF_FFFC;
            m_cap   = NOP;
            m_valid = 1'b0;
        end else if (!st) begin
            if (BC && (m_pc >= DEPTH * 4)) begin
                m_cap   = NOP;
                m_fault = 1'b1;
            end else begin
                m_cap = tb_mem[(m_pc / 4) % DEPTH];
            end
            m_valid = 1'b1;
            m_pc    = m_pc + 32'd4;
        end
        if (we) tb_mem[wa] = wd;
    endtask

    initial begin
        reset_n = 1'b0;
        drive(1'b0, 1'b0, 32'h0);
        prog_we = 1'b0; prog_addr = '0; prog_data = '0;

        // Program image: four known words then a distinct pattern elsewhere.
        tb_mem[0] = 32'h1111_1111;
        tb_mem[1] = 32'h2222_2222;
        tb_mem[2] = 32'h3333_3333;
        tb_mem[3] = 32'h4444_4444;
        for (int i = 4; i < DEPTH; i++) tb_mem[i] = 32'hA000_0000 + i;

        vecs[0]  = mk(0, 0, 0,            32'h1111_1111, 32'h4,   1, 0);
        vecs[1]  = mk(0, 0, 0,            32'h2222_2222, 32'h8,   1, 0);
        vecs[2]  = mk(1, 0, 0,            32'h2222_2222, 32'h8,   1, 0);
        vecs[3]  = mk(1, 0, 0,            32'h2222_2222, 32'h8,   1, 0);
        vecs[4]  = mk(0, 0, 0,            32'h3333_3333, 32'hC,   1, 0);
        vecs[5]  = mk(0, 0, 0,            32'h4444_4444, 32'h10,  1, 0);
        vecs[6]  = mk(0, 1, 32'h6,        NOP,           32'h4,   0, 0);
        vecs[7]  = mk(0, 0, 0,            32'h2222_2222, 32'h8,   1, 0);
        vecs[8]  = mk(1, 1, 32'hC,        NOP,           32'hC,   0, 0);
        vecs[9]  = mk(1, 0, 0,            NOP,           32'hC,   0, 0);
        vecs[10] = mk(0, 0, 0,            32'h4444_4444, 32'h10,  1, 0);
        vecs[11] = mk(0, 1, 32'hF8,       NOP,           32'hF8,  0, 0);
        vecs[12] = mk(0, 0, 0,            32'hA000_003E, 32'hFC,  1, 0);
        vecs[13] = mk(0, 0, 0,            32'hA000_003F, 32'h100, 1, 0);
        vecs[14] = mk(0, 0, 0, BC ? NOP : 32'h1111_1111, 32'h104, 1, BC);
        vecs[15] = mk(0, 1, 32'h0,        NOP,           32'h0,   0, BC);
        vecs[16] = mk(0, 0, 0,            32'h1111_1111, 32'h4,   1, BC);
        vecs[17] = mk(0, 1, 32'hFFFF_FFFF, NOP,          32'hFFFF_FFFC, 0, BC);
        vecs[18] = mk(0, 0, 0, BC ? NOP : 32'hA000_003F, 32'h0,   1, BC);

        #1;
        chk_all("reset", 32'h0, 32'h0, 1'b0, 1'b0);

        // Load memory while held in reset.
        for (int i = 0; i < DEPTH; i++) begin
            prog_we = 1'b1; prog_addr = 6'(i); prog_data = tb_mem[i];
            step();
        end
        prog_we = 1'b0;
        chk_all("in_reset_after_load", 32'h0, 32'h0, 1'b0, 1'b0);
        reset_n = 1'b1;

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].st, vecs[i].br, vecs[i].tgt);
            step();
            chk_all($sformatf("vec%0d", i), vecs[i].cap, vecs[i].pc, vecs[i].valid,
                    vecs[i].fault);
        end

        // Read-before-write: pc=0, overwrite word 0 while fetching it.
        drive(0, 0, 0); prog_we = 1'b1; prog_addr = 6'd0; prog_data = 32'h5555_5555;
        step();
        prog_we = 1'b0; tb_mem[0] = 32'h5555_5555;
        chk("rbw_old", captured_data, 32'h1111_1111);
        drive(0, 1, 32'h0); step();
        drive(0, 0, 0); step();
        chk("rbw_new", captured_data, 32'h5555_5555);

        // Write during stall lands; output held.
        drive(1, 0, 0); prog_we = 1'b1; prog_addr = 6'd2; prog_data = 32'h6666_6666;
        step();
        prog_we = 1'b0; tb_mem[2] = 32'h6666_6666;
        chk("stall_write_hold", captured_data, 32'h5555_5555);
        drive(0, 1, 32'h8); step();
        drive(0, 0, 0); step();
        chk("stall_write_seen", captured_data, 32'h6666_6666);
        chk("fault_still_sticky", {31'd0, fault}, {31'd0, BC});

        // Asynchronous reset between edges.
        #3 reset_n = 1'b0;
        #1;
        chk_all("async_reset", 32'h0, 32'h0, 1'b0, 1'b0);
        step();
        #2 reset_n = 1'b1;

        // Randomised run against the reference model.
        m_pc = 32'h0; m_cap = 32'h0; m_valid = 1'b0; m_fault = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic        st, br, we;
            logic [31:0] tgt, wd;
            logic [5:0]  wa;
            st  = ($urandom % 4) == 0;
            br  = ($urandom % 8) == 0;
            tgt = (($urandom % 6) == 0) ? $urandom : 32'($urandom_range(0, 300));
            we  = ($urandom % 5) == 0;
            wa  = 6'($urandom);
            wd  = $urandom;
            drive(st, br, tgt);
            prog_we = we; prog_addr = wa; prog_data = wd;
            step();
            model_edge(st, br, tgt, we, wa, wd);
            chk_all($sformatf("rand%0d", n), m_cap, m_pc, m_valid, m_fault);
        end
        prog_we = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
Front-end instruction fetch stage of the processor pipeline. Holds the program counter (PC), reads one 32-bit instruction word per clock from a local instruction memory and presents it registered on captured_data for decode. Supports stall, branch redirect, and a synchronous program-load write port used to fill the memory before execution.

Parameters:
DEPTH, 64, instruction memory size in 32-bit words (power of two, >= 2)
RESET_PC, 32'h0000_0000, PC value loaded on reset (word aligned)
NOP_INSTR, 32'h0000_0000, instruction word driven on flush and out-of-range fetch

Ports:
clk  in  1  pipeline clock, rising-edge active
reset_n  in  1  asynchronous active-low reset
stall  in  1  hold PC and captured_data this cycle
branch_taken  in  1  redirect PC to branch_target this cycle
branch_target  in  32  redirect byte address; bits [1:0] ignored and forced to 0
prog_we  in  1  instruction memory write enable
prog_addr  in  log2(DEPTH)  word address for the program write
prog_data  in  32  word written to the instruction memory
captured_data  out  32  fetched instruction, registered
pc  out  32  current PC (address of the next fetch)
valid  out  1  captured_data holds a real fetched instruction
fault  out  1  sticky out-of-range fetch flag (see Optional Feature)

Behaviour:
- Reset (reset_n low, asynchronous): pc=RESET_PC, captured_data=0, valid=0, fault=0. Memory contents are not reset.
- Memory word index = pc[log2(DEPTH)+1:2]. Read is synchronous and feeds captured_data directly. Latency is 1 cycle from the PC value to captured_data.
- Priority per rising edge: branch_taken > stall > normal.
- Normal (no stall, no branch): captured_data <= mem[index(pc)], valid <= 1, pc <= pc + 4. Addition is modulo 2^32 and wraps 32'hFFFF_FFFC to 0.
- Stall (branch_taken=0): pc, captured_data and valid all hold.
- Branch (branch_taken=1, stall ignored): pc <= {branch_target[31:2],2'b00}, captured_data <= NOP_INSTR, valid <= 0. The first instruction at the target appears on the following edge.
- Program write: on a rising edge with prog_we=1, mem[prog_addr] <= prog_data. The write is independent of stall and branch, and works while in reset.
- Write and fetch to the same word on the same edge: the fetch returns the old data (read-before-write).
- First edge after reset release fetches mem[index(RESET_PC)].
- Reset asserted mid-stream: outputs return to reset values immediately. The pipeline restarts from RESET_PC.

Optional Feature:
IF_BOUNDS_CHECK_EN
- Defined: a fetch with pc >= DEPTH*4 loads captured_data <= NOP_INSTR and valid <= 1, and sets fault=1. fault stays high until reset. pc still advances or redirects normally.
- Undefined: the index wraps modulo DEPTH (upper pc bits ignored). fault is tied to 0.

Test Plan:
- Reset then load: preload mem[0..3] = 32'h11111111, 22222222, 33333333, 44444444 via prog_we, then release reset_n. Over edges 1-4, captured_data = 11111111, 22222222, 33333333, 44444444; valid=1 from edge 1; pc = 4, 8, C, 10.
- Stall: hold stall=1 for 2 cycles after captured_data=22222222 -> captured_data stays 22222222 and pc stays 8. After release the next value is 33333333.
- Branch: with branch_taken=1 and branch_target=32'h0000_0006 -> next edge gives captured_data=0 (NOP), valid=0, pc=4. The following edge gives captured_data=22222222.
- Branch plus stall on the same edge -> branch wins (pc=target, valid=0).
- Wrap/bounds: run pc to DEPTH*4=0x100. Without the macro, captured_data = mem[0] = 11111111 and fault=0. With IF_BOUNDS_CHECK_EN, captured_data=0 and fault=1, and fault stays 1 until reset_n is pulsed.
- Async reset mid-run: drop reset_n between clock edges -> pc=0, captured_data=0 and valid=0 immediately, without waiting for a clock edge.
